// File: rtl/heap_pkg.sv
// Shared types and defaults for the min-heap controller and its size counter.
package heap_pkg;

    localparam int unsigned SIZE_W    = 8;
    localparam int unsigned DEF_DW    = 8;
    localparam int unsigned DEF_DEPTH = 15;
    localparam int unsigned DEF_IW    = 9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2,
        FIN  = 2'd3
    } state_t;

endpackage

// File: rtl/heap_min_sel.sv
// Smaller-child selector for sift-down: picks the right child only when it
// exists and is strictly smaller, so ties resolve to the left child.
module heap_min_sel #(
    parameter int unsigned DW = 8
) (
    input  logic [DW-1:0] left_key,
    input  logic [DW-1:0] right_key,
    input  logic          right_valid,
    output logic          sel_right,
    output logic [DW-1:0] min_key
);

    // Strict compare keeps equal keys on the left branch
    always_comb begin
        sel_right = right_valid && (right_key < left_key);
        min_key   = sel_right ? right_key : left_key;
    end

endmodule

// File: rtl/heap_ctrl.sv
// Binary min-heap controller: insert (sift-up) and extract-min (sift-down),
// one compare/swap per clock; heap size is kept by an external counter fed
// by the inc/dec pulses and read back on size.
module heap_ctrl
    import heap_pkg::*;
#(
    parameter int unsigned DW    = DEF_DW,
    parameter int unsigned DEPTH = DEF_DEPTH,
    parameter int unsigned IW    = DEF_IW
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [DW-1:0]     din,
    input  logic [SIZE_W-1:0] size,
    output logic              ready,
    output logic [DW-1:0]     dout,
    output logic              dout_valid,
    output logic              inc,
    output logic              dec,
    output logic              err
);

    localparam int unsigned AW  = $clog2(DEPTH + 1);
    localparam logic [IW-1:0] ONE = IW'(1);

    state_t        state;
    logic [DW-1:0] heap [0:(1 << AW) - 1];
    logic [IW-1:0] idx;
    logic [IW-1:0] last;

    logic [IW-1:0] sz_ext;
    logic [IW-1:0] sz_next;
    logic [IW-1:0] parent;
    logic [IW-1:0] left;
    logic [IW-1:0] right;
    logic [IW-1:0] child;
    logic [DW-1:0] cur_key;
    logic [DW-1:0] par_key;
    logic [DW-1:0] left_key;
    logic [DW-1:0] right_key;
    logic [DW-1:0] min_key;
    logic          right_ok;
    logic          sel_right;

    // Neighbour indices and keys around the current position; out-of-range
    // reads alias harmless entries and are masked by the bounds checks
    always_comb begin
        sz_ext    = IW'(size);
        sz_next   = sz_ext + ONE;
        parent    = idx >> 1;
        left      = idx << 1;
        right     = left + ONE;
        right_ok  = (right <= last);
        cur_key   = heap[idx[AW-1:0]];
        par_key   = heap[parent[AW-1:0]];
        left_key  = heap[left[AW-1:0]];
        right_key = heap[right[AW-1:0]];
        child     = sel_right ? right : left;
    end

    heap_min_sel #(
        .DW (DW)
    ) u_min_sel (
        .left_key    (left_key),
        .right_key   (right_key),
        .right_valid (right_ok),
        .sel_right   (sel_right),
        .min_key     (min_key)
    );

    // Control FSM with registered pulses; pulses are raised on entry to FIN
    // so the counter updates on the edge that returns to IDLE
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            ready      <= 1'b1;
            dout       <= '0;
            dout_valid <= 1'b0;
            inc        <= 1'b0;
            dec        <= 1'b0;
            err        <= 1'b0;
            idx        <= '0;
            last       <= '0;
        end else begin
            dout_valid <= 1'b0;
            inc        <= 1'b0;
            dec        <= 1'b0;
            err        <= 1'b0;
            case (state)
                IDLE: begin
                    if (pop) begin
                        if (size == '0) begin
                            err <= 1'b1;
                        end else begin
                            dout    <= heap[1];
                            heap[1] <= heap[sz_ext[AW-1:0]];
                            last    <= sz_ext - ONE;
                            idx     <= ONE;
                            ready   <= 1'b0;
                            state   <= DOWN;
                        end
                    end else if (push) begin
                        if (size == SIZE_W'(DEPTH)) begin
                            err <= 1'b1;
                        end else begin
                            heap[sz_next[AW-1:0]] <= din;
                            idx   <= sz_next;
                            ready <= 1'b0;
                            state <= UP;
                        end
                    end
                end
                UP: begin
                    if (idx == ONE || par_key <= cur_key) begin
                        inc   <= 1'b1;
                        state <= FIN;
                    end else begin
                        heap[idx[AW-1:0]]    <= par_key;
                        heap[parent[AW-1:0]] <= cur_key;
                        idx                  <= parent;
                    end
                end
                DOWN: begin
                    if (left > last || !(min_key < cur_key)) begin
                        dec        <= 1'b1;
                        dout_valid <= 1'b1;
                        state      <= FIN;
                    end else begin
                        heap[idx[AW-1:0]]   <= min_key;
                        heap[child[AW-1:0]] <= cur_key;
                        idx                 <= child;
                    end
                end
                FIN: begin
                    ready <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    ready <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
